rv_go_lsu: RTL and testbench

Load/store unit between the core's memory-access outputs and a valid/ready data-memory bus. It captures one load or store request per instruction, aligns store data into byte lanes, and runs the bus handshake. It then returns a sign- or zero-extended load result to the write-back mux. It holds the core with a stall signal until the access completes.

---
 rtl/rv_go_lsu_pkg.sv | 18 +
 rtl/rv_go_lsu_if.sv | 17 +
 rtl/rv_go_lsu_align.sv | 51 +++++
 rtl/rv_go_lsu.sv | 105 ++++++++++
 tb/tb_rv_go_lsu.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/rv_go_lsu_pkg.sv
// Shared types and constants for the rv_go_lsu load/store unit.
package rv_go_lsu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   // funct3 bit that selects zero-extension on loads
   localparam int OP_UNSIGNED_BIT = 2;

endpackage

// File: rtl/rv_go_lsu_if.sv
// Valid/ready data-memory bus between the LSU (master) and the memory (slave).
interface rv_go_lsu_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          valid;
   logic          ready;
   logic          we;
   logic [AW-1:0] addr;
   logic [3:0]    be;
   logic [DW-1:0] wdata;
   logic          rvalid;
   logic [DW-1:0] rdata;

   modport master (output valid, we, addr, be, wdata, input ready, rvalid, rdata);
   modport slave  (input valid, we, addr, be, wdata, output ready, rvalid, rdata);
endinterface

// File: rtl/rv_go_lsu_align.sv
// Byte-lane logic: enables, store replication, load extraction/extension, misalignment.
// RV_GO_LSU_MISALIGN_CHECK_EN enables misalignment detection; otherwise misalign is 0.
module rv_go_lsu_align
   import rv_go_lsu_pkg::*;
(
   input  logic [2:0]  op,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_lane,
   output logic [31:0] rdata_ext,
   output logic        misalign
);

   logic [7:0]  lb;
   logic [15:0] lh;
   logic        uns;

   always_comb begin
      be         = 4'b1111;
      wdata_lane = wdata;
      rdata_ext  = rdata;
      misalign   = 1'b0;
      uns        = op[OP_UNSIGNED_BIT];
      lb         = rdata[{addr_lo, 3'b000} +: 8];
      // halves always pick a lane by addr[1], so an unchecked odd half still lands on a lane
      lh         = addr_lo[1] ? rdata[31:16] : rdata[15:0];
      case (op[1:0])
         SZ_B: begin
            be         = 4'b0001 << addr_lo;
            wdata_lane = {4{wdata[7:0]}};
            rdata_ext  = uns ? {24'd0, lb} : {{24{lb[7]}}, lb};
         end
         SZ_H: begin
            be         = 4'b0011 << {addr_lo[1], 1'b0};
            wdata_lane = {2{wdata[15:0]}};
            rdata_ext  = uns ? {16'd0, lh} : {{16{lh[15]}}, lh};
`ifdef RV_GO_LSU_MISALIGN_CHECK_EN
            misalign   = addr_lo[0];
`endif
         end
         default: begin
`ifdef RV_GO_LSU_MISALIGN_CHECK_EN
            misalign   = |addr_lo;
`endif
         end
      endcase
   end

endmodule

// File: rtl/rv_go_lsu.sv
// Load/store unit: captures one request per instruction and runs the bus handshake.
// RV_GO_LSU_MISALIGN_CHECK_EN (see rv_go_lsu_align) short-circuits misaligned accesses to DONE.
module rv_go_lsu
   import rv_go_lsu_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_i,
   input  logic          we_i,
   input  logic [2:0]    op_i,
   input  logic [AW-1:0] addr_i,
   input  logic [DW-1:0] wdata_i,
   output logic [DW-1:0] rdata_o,
   output logic          stall_o,
   output logic          misalign_o,
   rv_go_lsu_if.master   bus
);

   // state | meaning
   // IDLE  | waiting for req_i; captures the request
   // REQ   | bus_valid high until the bus accepts
   // RESP  | load accepted, waiting for read data
   // DONE  | one-cycle completion; core advances on the edge that ends it

   state_t        state_q, state_n;
   logic [AW-1:0] addr_q;
   logic [2:0]    op_q;
   logic          we_q;
   logic [DW-1:0] wdata_q;
   logic [DW-1:0] rdata_q;
   logic          mis_q;

   logic [2:0]    op_sel;
   logic [1:0]    addr_lo_sel;
   logic [3:0]    be;
   logic [31:0]   wdata_lane;
   logic [31:0]   rdata_ext;
   logic          mis;

   // in IDLE the misalign check must see the incoming request, not the stale capture
   assign op_sel      = (state_q == IDLE) ? op_i : op_q;
   assign addr_lo_sel = (state_q == IDLE) ? addr_i[1:0] : addr_q[1:0];

   rv_go_lsu_align u_align (
      .op         (op_sel),
      .addr_lo    (addr_lo_sel),
      .wdata      (wdata_q),
      .rdata      (bus.rdata),
      .be         (be),
      .wdata_lane (wdata_lane),
      .rdata_ext  (rdata_ext),
      .misalign   (mis)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_n;
   end

   always_comb begin
      state_n = state_q;
      case (state_q)
         IDLE:    if (req_i) state_n = mis ? DONE : REQ;
         REQ:     if (bus.ready) state_n = we_q ? DONE : RESP;
         RESP:    if (bus.rvalid) state_n = DONE;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q  <= '0;
         op_q    <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
         mis_q   <= 1'b0;
      end else begin
         if (state_q == IDLE && req_i) begin
            addr_q  <= addr_i;
            op_q    <= op_i;
            we_q    <= we_i;
            wdata_q <= wdata_i;
            mis_q   <= mis;
            rdata_q <= '0;
         end
         if (state_q == RESP && bus.rvalid) rdata_q <= rdata_ext;
      end
   end

   assign bus.valid  = (state_q == REQ);
   assign bus.we     = (state_q == REQ) & we_q;
   assign bus.addr   = {addr_q[AW-1:2], 2'b00};
   assign bus.be     = (state_q == REQ) ? be : 4'b0000;
   assign bus.wdata  = (state_q == REQ) ? wdata_lane : '0;

   assign rdata_o    = rdata_q;
   assign stall_o    = req_i & (state_q != DONE);
   assign misalign_o = (state_q == DONE) & mis_q;

endmodule

// File: tb/tb_rv_go_lsu.sv
// Scoreboard bench for rv_go_lsu: expected accesses are queued at drive time and checked at DONE.
module tb_rv_go_lsu;
   import rv_go_lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_i;
   logic        we_i;
   logic [2:0]  op_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic [31:0] rdata_o;
   logic        stall_o;
   logic        misalign_o;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic [3:0]  be;
      logic        we;
      logic        mis;
      int          stalls;
   } exp_t;

   exp_t sb[$];

   rv_go_lsu_if #(.AW(32), .DW(32)) bus ();

   rv_go_lsu #(.AW(32), .DW(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_i      (req_i),
      .we_i       (we_i),
      .op_i       (op_i),
      .addr_i     (addr_i),
      .wdata_i    (wdata_i),
      .rdata_o    (rdata_o),
      .stall_o    (stall_o),
      .misalign_o (misalign_o),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic m_mis(input logic [2:0] op, input logic [31:0] a);
`ifdef RV_GO_LSU_MISALIGN_CHECK_EN
      if (op[1]) return a[1:0] != 2'b00;
      if (op[0]) return a[0];
      return 1'b0;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [3:0] m_be(input logic [2:0] op, input logic [31:0] a);
      if (op[1]) return 4'b1111;
      if (op[0]) return a[1] ? 4'b1100 : 4'b0011;
      case (a[1:0])
         2'd0: return 4'b0001;
         2'd1: return 4'b0010;
         2'd2: return 4'b0100;
         default: return 4'b1000;
      endcase
   endfunction

   function automatic logic [31:0] m_wd(input logic [2:0] op, input logic [31:0] d);
      if (op[1]) return d;
      if (op[0]) return {d[15:0], d[15:0]};
      return {d[7:0], d[7:0], d[7:0], d[7:0]};
   endfunction

   function automatic logic [31:0] m_rd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
      logic [7:0]  b;
      logic [15:0] h;
      if (m_mis(op, a)) return 32'd0;
      if (op[1]) return d;
      if (op[0]) begin
         h = a[1] ? d[31:16] : d[15:0];
         if (op[2] || !h[15]) return {16'h0000, h};
         return {16'hFFFF, h};
      end
      case (a[1:0])
         2'd0: b = d[7:0];
         2'd1: b = d[15:8];
         2'd2: b = d[23:16];
         default: b = d[31:24];
      endcase
      if (op[2] || !b[7]) return {24'h000000, b};
      return {24'hFFFFFF, b};
   endfunction

   task automatic access(input logic we, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rresp,
                         input int rdy_wait, input int rv_wait);
      exp_t e;
      exp_t got;
      int stalls = 0;
      int req_cnt = 0;
      int rv_cnt = 0;
      bit accepted = 0;
      bit seen_valid = 0;
      bit done = 0;
      e.addr   = {addr[31:2], 2'b00};
      e.wdata  = m_wd(op, wdata);
      e.be     = m_be(op, addr);
      e.we     = we;
      e.mis    = m_mis(op, addr);
      e.rdata  = m_rd(op, addr, rresp);
      e.stalls = e.mis ? 1 : (we ? 2 + rdy_wait : 3 + rdy_wait + rv_wait);
      sb.push_back(e);

      @(negedge clk);
      req_i = 1'b1; we_i = we; op_i = op; addr_i = addr; wdata_i = wdata;
      bus.ready = 1'b0; bus.rvalid = 1'b0; bus.rdata = 32'd0;
      for (int cyc = 0; cyc < 40 && !done; cyc++) begin
         #1;
         if (stall_o) stalls++;
         else begin
            got = sb.pop_front();
            chk("stall_cycles", 32'(stalls), 32'(got.stalls));
            chk("misalign_o", 32'(misalign_o), 32'(got.mis));
            chk("bus_issued", 32'(seen_valid), 32'(!got.mis));
            if (!got.we) chk("rdata_o", rdata_o, got.rdata);
            done = 1;
         end
         if (!done) begin
            if (bus.valid) begin
               if (!seen_valid) begin
                  chk("bus_addr", bus.addr, sb[0].addr);
                  chk("bus_be", 32'(bus.be), 32'(sb[0].be));
                  chk("bus_we", 32'(bus.we), 32'(sb[0].we));
                  if (sb[0].we) chk("bus_wdata", bus.wdata, sb[0].wdata);
                  seen_valid = 1;
               end
               bus.ready = (req_cnt >= rdy_wait);
               if (bus.ready) accepted = 1;
               req_cnt++;
            end else begin
               bus.ready = 1'b0;
               if (accepted && !we) begin
                  bus.rvalid = (rv_cnt == rv_wait);
                  bus.rdata  = rresp;
                  rv_cnt++;
               end
            end
            @(negedge clk);
         end
      end
      if (!done) begin
         chk("timeout", 32'd1, 32'd0);
         void'(sb.pop_front());
      end
      req_i = 1'b0; bus.ready = 1'b0; bus.rvalid = 1'b0;
   endtask

   initial begin
      rst = 1'b0; req_i = 1'b1; we_i = 1'b0; op_i = 3'd0; addr_i = 32'd0; wdata_i = 32'd0;
      bus.ready = 1'b0; bus.rvalid = 1'b0; bus.rdata = 32'd0;
      #12;
      chk("rst_valid", 32'(bus.valid), 32'd0);
      chk("rst_we", 32'(bus.we), 32'd0);
      chk("rst_be", 32'(bus.be), 32'd0);
      chk("rst_addr", bus.addr, 32'd0);
      chk("rst_wdata", bus.wdata, 32'd0);
      chk("rst_rdata", rdata_o, 32'd0);
      chk("rst_misalign", 32'(misalign_o), 32'd0);
      chk("rst_stall", 32'(stall_o), 32'd1);
      req_i = 1'b0;
      @(negedge clk); rst = 1'b1;
      @(negedge clk);

      access(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'd0, 0, 0);
      access(1'b1, 3'b000, 32'h103, 32'h000000A5, 32'd0, 0, 0);
      access(1'b0, 3'b000, 32'h102, 32'd0, 32'h00800000, 0, 0);
      access(1'b0, 3'b100, 32'h102, 32'd0, 32'h00800000, 0, 0);
      access(1'b0, 3'b001, 32'h102, 32'd0, 32'hBEEF1234, 2, 2);
      access(1'b0, 3'b010, 32'h101, 32'd0, 32'hCAFEF00D, 0, 0);
      access(1'b1, 3'b001, 32'h202, 32'h00001357, 32'd0, 1, 0);
      access(1'b0, 3'b101, 32'h203, 32'd0, 32'h80F17F00, 0, 1);

      for (int i = 0; i < 12; i++) begin
         logic        w;
         logic [2:0]  op;
         w  = 1'($urandom_range(0, 1));
         op = {w ? 1'b0 : 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2))};
         access(w, op, 32'h1000 + 32'($urandom_range(0, 255)), $urandom, $urandom,
                $urandom_range(0, 2), $urandom_range(0, 2));
      end

      // reset while waiting for a read response; the late rvalid must be dropped
      @(negedge clk);
      req_i = 1'b1; we_i = 1'b0; op_i = 3'b010; addr_i = 32'h300; bus.ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      bus.ready = 1'b0;
      chk("pre_rst_state", 32'(dut.state_q), 32'(RESP));
      rst = 1'b0;
      #1;
      chk("mid_rst_state", 32'(dut.state_q), 32'(IDLE));
      chk("mid_rst_valid", 32'(bus.valid), 32'd0);
      chk("mid_rst_stall", 32'(stall_o), 32'd1);
      req_i = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'h12345678;
      @(negedge clk); rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("post_rst_state", 32'(dut.state_q), 32'(IDLE));
      chk("post_rst_rdata", rdata_o, 32'd0);
      chk("post_rst_misalign", 32'(misalign_o), 32'd0);
      chk("post_rst_stall", 32'(stall_o), 32'd0);
      bus.rvalid = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
